imem_stream_loader: RTL

//  Upstream feeder for fetch_stage: owns fetch_addr / fetch_addr_valid / fetched_data.

---
 rtl/imem_stream_loader.sv | 102 ++++++++++
 1 files changed

// File: rtl/imem_stream_loader.sv
// imem_stream_loader: serially loads a program into a DEPTH x 64-bit buffer and
// streams it to fetch as aligned 2-instruction packets with stall and redirect.
module imem_stream_loader #(
   parameter int          DEPTH     = 16,
   parameter int          CHUNK_W   = 10,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load_en,
   input  logic                    load_strobe,
   input  logic [CHUNK_W-1:0]      load_data,
   input  logic                    start,
   input  logic                    ext_stall,
   input  logic                    ext_flush,
   input  logic [31:0]             redirect_pc,
   output logic [31:0]             fetch_addr,
   output logic                    fetch_addr_valid,
   output logic [63:0]             fetched_data,
   output logic [$clog2(DEPTH):0]  loaded_words,
   output logic                    overflow,
   output logic [1:0]              state_o
);
   localparam int IW  = $clog2(DEPTH);
   localparam int LW  = IW + 1;
   localparam int NCH = (64 + CHUNK_W - 1) / CHUNK_W;
   localparam int AW  = NCH * CHUNK_W;
   localparam int CW  = NCH > 1 ? $clog2(NCH) : 1;
   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
   state_t          state;
   logic [63:0]     mem [DEPTH];
   logic [AW-1:0]   acc, acc_n;
   logic [CW-1:0]   chunk_cnt;
   logic [LW-1:0]   rd_idx, nxt_idx;
   logic [31:0]     fl_idx;
   logic            fl_hit, full, accept, last_chunk;
   // chunk 0 starts a fresh word; bits beyond 63 of the last chunk are dropped at commit
   always_comb begin
      acc_n = chunk_cnt == '0 ? '0 : acc;
      acc_n[chunk_cnt*CHUNK_W +: CHUNK_W] = load_data;
   end
   assign full       = loaded_words == LW'(DEPTH);
   assign accept     = state == LOAD && load_en && load_strobe && !full;
   assign last_chunk = chunk_cnt == CW'(NCH - 1);
   assign nxt_idx    = rd_idx + LW'(1);
   assign fl_idx     = (redirect_pc - BASE_ADDR) >> 3;
   assign fl_hit     = fl_idx < 32'(loaded_words);
   assign state_o    = state;
   always_ff @(posedge clk)
      if (accept && last_chunk) mem[loaded_words[IW-1:0]] <= acc_n[63:0];
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= IDLE;
         fetch_addr       <= '0;
         fetch_addr_valid <= 1'b0;
         fetched_data     <= '0;
         loaded_words     <= '0;
         overflow         <= 1'b0;
         chunk_cnt        <= '0;
         rd_idx           <= '0;
         acc              <= '0;
      end else if ((state == RUN || state == DONE) && ext_flush) begin
         fetch_addr       <= redirect_pc & ~32'd7;
         fetch_addr_valid <= fl_hit;
         state            <= fl_hit ? RUN : DONE;
         if (fl_hit) begin
            rd_idx       <= LW'(fl_idx);
            fetched_data <= mem[fl_idx[IW-1:0]];
         end
      end else if ((state == IDLE || state == DONE) && load_en) begin
         state        <= LOAD;
         loaded_words <= '0;
         chunk_cnt    <= '0;
      end else if (state == IDLE && start && loaded_words != '0) begin
         state            <= RUN;
         rd_idx           <= '0;
         fetch_addr       <= BASE_ADDR;
         fetch_addr_valid <= 1'b1;
         fetched_data     <= mem[0];
      end else if (state == LOAD) begin
         if (!load_en) begin
            state     <= IDLE;
            chunk_cnt <= '0;
         end else if (load_strobe && full) begin
            overflow <= 1'b1;
         end else if (accept) begin
            acc       <= acc_n;
            chunk_cnt <= last_chunk ? '0 : chunk_cnt + CW'(1);
            if (last_chunk) loaded_words <= loaded_words + LW'(1);
         end
      end else if (state == RUN && !ext_stall) begin
         rd_idx <= nxt_idx;
         if (nxt_idx == loaded_words) begin
            fetch_addr_valid <= 1'b0;
            state            <= DONE;
         end else begin
            fetch_addr   <= fetch_addr + 32'd8;
            fetched_data <= mem[nxt_idx[IW-1:0]];
         end
      end
   end
endmodule
